// File: rtl/pd_resp_pkg.sv
// Shared types and default values for the retention domain responder.
package pd_resp_pkg;

   // Responder state, also exported on pd_state for observation.
   typedef enum logic [1:0] {
      PD_ON    = 2'd0,
      PD_OFF   = 2'd1,
      PD_RAMP  = 2'd2,
      PD_READY = 2'd3
   } pd_state_t;

   localparam logic [31:0] CORRUPT_VAL_DEF = 32'hDEAD_BEEF;
   localparam logic [31:0] ISO_VAL_DEF     = 32'h0000_0000;
   localparam int          RAMP_CYCLES_DEF = 8;

endpackage

// File: rtl/retention_bank.sv
// Always-on shadow bank: whole-array parallel load, whole-array parallel read.
// Only rst_n clears it; the rail switch has no effect on its contents.
module retention_bank #(
   parameter int REG_W    = 32,
   parameter int NUM_REGS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_en,
   input  logic [NUM_REGS*REG_W-1:0] load_data,
   output logic [NUM_REGS*REG_W-1:0] bank_data
);

   logic [NUM_REGS*REG_W-1:0] bank;

   // Snapshot the full live array in a single cycle when load_en is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
      end else if (load_en) begin
         bank <= load_data;
      end
   end

   assign bank_data = bank;

endmodule

// File: rtl/retention_domain_responder.sv
// Power-domain side of the save/restore/isolation/power-switch handshake:
// switchable live registers, an always-on shadow bank, an isolated read port
// and a rail-ramp timer that reports power_up_done back to the controller.
//
// Request semantics: save and restore are level requests; only their rising
// edge (current high, previous cycle low) triggers a copy. Writes have no
// handshake: a write strobe is either accepted on the edge or silently dropped.
module retention_domain_responder
   import pd_resp_pkg::*;
#(
   parameter int               REG_W       = 32,
   parameter int               NUM_REGS    = 4,
   parameter int               RAMP_CYCLES = RAMP_CYCLES_DEF,
   parameter logic [31:0]      CORRUPT_VAL = CORRUPT_VAL_DEF,
   parameter logic [REG_W-1:0] ISO_VAL     = REG_W'(ISO_VAL_DEF)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        save,
   input  logic                        restore,
   input  logic                        iso_en,
   input  logic                        power_switch_en,
   input  logic                        wake_req,
   input  logic                        wr_en,
   input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
   input  logic [REG_W-1:0]            wr_data,
   input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
   output logic [REG_W-1:0]            rd_data,
   output logic                        power_up_done,
   output logic                        ret_valid,
   output logic                        err_protocol,
   output logic [1:0]                  pd_state
);

   localparam int               CNT_W     = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RAMP_CYCLES - 1);
   localparam logic [REG_W-1:0] CORRUPT_W = REG_W'(CORRUPT_VAL);

   pd_state_t                 state, state_nx;
   logic                      save_q, restore_q;
   logic                      save_rise, restore_rise;
   logic [CNT_W-1:0]          cnt;
   logic [REG_W-1:0]          live [NUM_REGS];
   logic [NUM_REGS*REG_W-1:0] live_flat;
   logic [NUM_REGS*REG_W-1:0] shadow_flat;

   logic corrupt_all, do_save, do_restore, wr_ok, err_set, cnt_clr, cnt_inc;

   assign save_rise    = save & ~save_q;
   assign restore_rise = restore & ~restore_q;
   assign pd_state     = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PD_ON;
      else        state <= state_nx;
   end

   // Next-state decode plus the per-cycle control strobes for the datapath.
   always_comb begin
      state_nx    = state;
      corrupt_all = 1'b0;
      do_save     = 1'b0;
      do_restore  = 1'b0;
      wr_ok       = 1'b0;
      err_set     = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      case (state)
         PD_ON: begin
            if (!power_switch_en) begin
               state_nx    = PD_OFF;
               corrupt_all = 1'b1;
            end
            // Simultaneous edges are ambiguous, so neither copy is honoured.
            if (save_rise && restore_rise) begin
               err_set = 1'b1;
            end else begin
               if (save_rise) do_save = 1'b1;
               if (restore_rise) begin
                  if (ret_valid) do_restore = 1'b1;
                  else           err_set    = 1'b1;
               end
            end
            wr_ok = wr_en & ~iso_en & ~save & ~restore & power_switch_en;
         end
         PD_OFF: begin
            if (power_switch_en) begin
               state_nx = PD_ON;
               err_set  = 1'b1;
            end else if (wake_req) begin
               state_nx = PD_RAMP;
               cnt_clr  = 1'b1;
            end
         end
         PD_RAMP: begin
            if (power_switch_en) begin
               state_nx = PD_ON;
               err_set  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
               if (cnt == CNT_LAST) state_nx = PD_READY;
            end
         end
         PD_READY: begin
            if (power_switch_en) state_nx = PD_ON;
         end
         default: state_nx = PD_ON;
      endcase
      // Any save/restore edge while the rail is not on is a protocol slip.
      if (state != PD_ON && (save_rise || restore_rise)) err_set = 1'b1;
   end

   // Previous-cycle copies of the request levels for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         save_q    <= 1'b0;
         restore_q <= 1'b0;
      end else begin
         save_q    <= save;
         restore_q <= restore;
      end
   end

   // Rail-ramp counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
   end

   // Live registers: power-off corruption beats restore, restore beats writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) live[i] <= '0;
      end else if (corrupt_all) begin
         for (int i = 0; i < NUM_REGS; i++) live[i] <= CORRUPT_W;
      end else if (do_restore) begin
         for (int i = 0; i < NUM_REGS; i++) live[i] <= shadow_flat[i*REG_W +: REG_W];
      end else if (wr_ok) begin
         live[wr_addr] <= wr_data;
      end
   end

   // Flatten the live array for the shadow bank load port.
   always_comb begin
      live_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) live_flat[i*REG_W +: REG_W] = live[i];
   end

   retention_bank #(
      .REG_W    (REG_W),
      .NUM_REGS (NUM_REGS)
   ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (do_save),
      .load_data (live_flat),
      .bank_data (shadow_flat)
   );

   // Registered read port, clamped whenever the domain is isolated or not on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          rd_data <= '0;
      else if (state == PD_ON && !iso_en)  rd_data <= live[rd_addr];
      else                                 rd_data <= ISO_VAL;
   end

   // Status flags: ramp done level, snapshot valid, sticky protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         power_up_done <= 1'b0;
         ret_valid     <= 1'b0;
         err_protocol  <= 1'b0;
      end else begin
         power_up_done <= (state == PD_READY) && !power_switch_en;
         if (do_save) ret_valid    <= 1'b1;
         if (err_set) err_protocol <= 1'b1;
      end
   end

endmodule

// File: tb/tb_retention_domain_responder.sv
// Directed bench for retention_domain_responder with a read-data scoreboard.
module tb_retention_domain_responder;

   localparam int REG_W    = 32;
   localparam int NUM_REGS = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             save, restore, iso_en, power_switch_en, wake_req, wr_en;
   logic [1:0]       wr_addr, rd_addr;
   logic [REG_W-1:0] wr_data, rd_data;
   logic             power_up_done, ret_valid, err_protocol;
   logic [1:0]       pd_state;

   int checks = 0;
   int errors = 0;

   logic [REG_W-1:0] exp_q[$];
   logic [REG_W-1:0] model    [NUM_REGS];
   logic [REG_W-1:0] shadow_m [NUM_REGS];

   retention_domain_responder dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .save            (save),
      .restore         (restore),
      .iso_en          (iso_en),
      .power_switch_en (power_switch_en),
      .wake_req        (wake_req),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .power_up_done   (power_up_done),
      .ret_valid       (ret_valid),
      .err_protocol    (err_protocol),
      .pd_state        (pd_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      save = 0; restore = 0; iso_en = 0; power_switch_en = 1; wake_req = 0;
      wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         model[i]    = '0;
         shadow_m[i] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [REG_W-1:0] d);
      @(negedge clk);
      wr_en = 1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 0;
      model[a] = d;
   endtask

   task automatic read_expect(input logic [1:0] a, input logic [REG_W-1:0] e, input string tag);
      @(negedge clk);
      rd_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      chk(tag, rd_data, exp_q.pop_front());
   endtask

   task automatic pulse_save();
      @(negedge clk);
      save = 1;
      @(negedge clk);
      save = 0;
      for (int i = 0; i < NUM_REGS; i++) shadow_m[i] = model[i];
   endtask

   task automatic pulse_restore(input bit copies);
      @(negedge clk);
      restore = 1;
      @(negedge clk);
      restore = 0;
      if (copies) for (int i = 0; i < NUM_REGS; i++) model[i] = shadow_m[i];
   endtask

   initial begin
      rst_n = 1'b0;
      do_reset();
      // Reset values.
      rst_n = 1'b0;
      #1;
      chk("rst_state", pd_state, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_pud", power_up_done, 0);
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_err", err_protocol, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) read_expect(2'(i), 0, "rst_live");

      // Write then read back.
      do_write(2, 32'h1111_2222);
      read_expect(2, model[2], "wr_rd_reg2");

      // Full power cycle.
      do_write(1, 32'hA5A5_0001);
      pulse_save();
      chk("save_ret_valid", ret_valid, 1);
      @(negedge clk);
      iso_en = 1; power_switch_en = 0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("off_state", pd_state, 1);
      read_expect(1, 0, "off_iso_read");
      @(negedge clk);
      wake_req = 1;
      @(negedge clk);
      wake_req = 0;
      repeat (8) @(negedge clk);
      chk("ramp_pud_low_t8", power_up_done, 0);
      chk("ramp_ready_state", pd_state, 3);
      @(negedge clk);
      chk("ramp_pud_high_t9", power_up_done, 1);
      power_switch_en = 1;
      @(negedge clk);
      chk("on_state", pd_state, 0);
      chk("on_pud_low", power_up_done, 0);
      pulse_restore(1);
      @(negedge clk);
      iso_en = 0;
      read_expect(1, 32'hA5A5_0001, "restore_reg1");
      read_expect(2, 32'h1111_2222, "restore_reg2");
      chk("cycle_no_err", err_protocol, 0);

      // Early power_switch_en during ramp.
      @(negedge clk);
      power_switch_en = 0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'hDEAD_BEEF;
      @(negedge clk);
      wake_req = 1;
      @(negedge clk);
      wake_req = 0;
      @(negedge clk);
      chk("early_in_ramp", pd_state, 2);
      power_switch_en = 1;
      @(negedge clk);
      chk("early_state_on", pd_state, 0);
      chk("early_err", err_protocol, 1);
      for (int i = 0; i < NUM_REGS; i++) read_expect(2'(i), 32'hDEAD_BEEF, "early_corrupt");

      // Restore before any save.
      do_reset();
      chk("r2_ret_valid", ret_valid, 0);
      chk("r2_err_clear", err_protocol, 0);
      do_write(0, 32'h1234_5678);
      pulse_restore(0);
      chk("nosave_restore_err", err_protocol, 1);
      read_expect(0, 32'h1234_5678, "nosave_reg0");

      // Save and restore rising together.
      do_reset();
      do_write(3, 32'hCAFE_0003);
      pulse_save();
      do_write(3, 32'h0BAD_0003);
      chk("both_pre_err", err_protocol, 0);
      @(negedge clk);
      save = 1; restore = 1;
      @(negedge clk);
      save = 0; restore = 0;
      chk("both_err", err_protocol, 1);
      read_expect(3, 32'h0BAD_0003, "both_live_kept");
      pulse_restore(1);
      read_expect(3, 32'hCAFE_0003, "both_shadow_kept");

      // Asynchronous reset at ramp count 4.
      do_reset();
      do_write(1, 32'h0000_0077);
      pulse_save();
      chk("g_ret_valid", ret_valid, 1);
      @(negedge clk);
      power_switch_en = 0; iso_en = 1;
      @(negedge clk);
      wake_req = 1;
      @(negedge clk);
      wake_req = 0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", pd_state, 0);
      chk("arst_pud", power_up_done, 0);
      chk("arst_ret_valid", ret_valid, 0);
      chk("arst_rd_data", rd_data, 0);
      @(negedge clk);
      power_switch_en = 1; iso_en = 0; rst_n = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      read_expect(1, 0, "arst_live_cleared");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
